debounce_filter: RTL and testbench

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_filter.sv | 132 +++++++++++++
 tb/tb_debounce_filter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Synchronises a raw, possibly bouncing level, qualifies every
//               transition over STABLE_CNT+1 consecutive samples and counts
//               the transitions that were rejected as glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 16,
  parameter int GLITCH_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pulse_i,
  input  logic                glitch_clr_i,
  output logic                pulse_o,
  output logic                busy_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam int c_cnt_w = $clog2(STABLE_CNT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CNT);
  localparam logic [GLITCH_W-1:0] c_glitch_one = GLITCH_W'(1);

  // Reject parameterisations the filter cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_filter: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("debounce_filter: STABLE_CNT must be at least 1");
  end

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    QUAL_H = 2'd1,
    HIGH   = 2'd2,
    QUAL_L = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_pulse;
  logic [GLITCH_W-1:0]    r_glitch_cnt;
  logic                   w_s;
  logic                   w_glitch;

  // The oldest synchroniser stage is the only value the FSM ever looks at.
  assign w_s = r_sync[SYNC_STAGES-1];

  // A qualification aborted in either direction is a rejected glitch.
  assign w_glitch = ((r_state == QUAL_H) && !w_s) ||
                    ((r_state == QUAL_L) &&  w_s);

  // Metastability-hardening shift chain for the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_i};
    end
  end

  // Qualification FSM with registered output level and saturating glitch count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= LOW;
      r_cnt        <= '0;
      r_pulse      <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      case (r_state)
        LOW: begin
          if (w_s) begin
            r_state <= QUAL_H;
            r_cnt   <= c_cnt_one;
          end
        end
        QUAL_H: begin
          if (w_s) begin
            if (r_cnt == c_cnt_max) begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end else begin
            r_state <= LOW;
          end
        end
        HIGH: begin
          if (!w_s) begin
            r_state <= QUAL_L;
            r_cnt   <= c_cnt_one;
          end
        end
        QUAL_L: begin
          if (!w_s) begin
            if (r_cnt == c_cnt_max) begin
              r_state <= LOW;
              r_pulse <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end else begin
            r_state <= HIGH;
          end
        end
        default: begin
          r_state <= LOW;
          r_pulse <= 1'b0;
        end
      endcase

      // Clear has priority over a coincident glitch; the count never wraps.
      if (glitch_clr_i) begin
        r_glitch_cnt <= '0;
      end else if (w_glitch && (r_glitch_cnt != '1)) begin
        r_glitch_cnt <= r_glitch_cnt + c_glitch_one;
      end
    end
  end

  assign pulse_o      = r_pulse;
  assign busy_o       = (r_state == QUAL_H) || (r_state == QUAL_L);
  assign glitch_cnt_o = r_glitch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_filter
// Description : Scoreboard bench for debounce_filter. A driver applies one
//               input vector per cycle and pushes the expected outputs from a
//               disagreement-run reference model; a monitor pops and compares
//               after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_filter;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int GW     = 4;
  localparam int GMAX   = (1 << GW) - 1;

  typedef struct packed {
    logic          pulse;
    logic          busy;
    logic [GW-1:0] gcnt;
  } exp_t;

  logic          clk_i;
  logic          rst_ni;
  logic          pulse_i;
  logic          glitch_clr_i;
  logic          pulse_o;
  logic          busy_o;
  logic [GW-1:0] glitch_cnt_o;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  // Reference model: the input seen SYNC edges late; the output flips once the
  // delayed input has disagreed with it for STABLE+1 samples in a row.
  logic [SYNC-1:0] m_hist;
  logic            m_out;
  int              m_run;
  int              m_gcnt;

  debounce_filter #(
    .SYNC_STAGES (SYNC),
    .STABLE_CNT  (STABLE),
    .GLITCH_W    (GW)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pulse_i      (pulse_i),
    .glitch_clr_i (glitch_clr_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_hist = '0;
    m_out  = 1'b0;
    m_run  = 0;
    m_gcnt = 0;
  endfunction

  function automatic exp_t m_step(input logic p, input logic clr);
    logic s;
    logic glitch;
    exp_t e;
    s      = m_hist[SYNC-1];
    m_hist = {m_hist[SYNC-2:0], p};
    glitch = 1'b0;
    if (s != m_out) begin
      m_run++;
      if (m_run == STABLE + 1) begin
        m_out = s;
        m_run = 0;
      end
    end else begin
      glitch = (m_run > 0);
      m_run  = 0;
    end
    if (clr) m_gcnt = 0;
    else if (glitch && m_gcnt < GMAX) m_gcnt++;
    e.pulse = m_out;
    e.busy  = (m_run > 0);
    e.gcnt  = GW'(m_gcnt);
    return e;
  endfunction

  // One stimulus cycle; an optional reset pulse lands between clock edges.
  task automatic cyc(input logic p, input logic clr = 1'b0, input logic rst = 1'b0);
    @(negedge clk_i);
    if (rst) begin
      #1 rst_ni = 1'b0;
      #1;
      check("async_rst_pulse", int'(pulse_o), 0);
      check("async_rst_busy", int'(busy_o), 0);
      check("async_rst_gcnt", int'(glitch_cnt_o), 0);
      rst_ni = 1'b1;
      m_reset();
    end
    pulse_i      = p;
    glitch_clr_i = clr;
    exp_q.push_back(m_step(p, clr));
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) cyc(p);
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_pulse_o", int'(pulse_o), int'(e.pulse));
        check("mon_busy_o", int'(busy_o), int'(e.busy));
        check("mon_glitch_cnt_o", int'(glitch_cnt_o), int'(e.gcnt));
      end
    end
  end

  // Driver: directed scenarios followed by randomised bouncing.
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_ni       = 1'b0;
    pulse_i      = 1'b0;
    glitch_clr_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_i);
    #2;
    check("reset_pulse", int'(pulse_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_gcnt", int'(glitch_cnt_o), 0);
    rst_ni = 1'b1;
    hold(1'b0, 4);

    // Clean rise: output moves on edge 7, not edge 6.
    hold(1'b1, 7);
    check("rise_edge6_pulse", int'(pulse_o), 0);
    check("rise_edge6_busy", int'(busy_o), 1);
    cyc(1'b1);
    check("rise_edge7_pulse", int'(pulse_o), 1);
    check("rise_edge7_busy", int'(busy_o), 0);
    hold(1'b1, 3);

    // Low for 4 samples from HIGH is rejected.
    hold(1'b0, 4);
    hold(1'b1, 8);
    check("fall_glitch_pulse", int'(pulse_o), 1);
    check("fall_glitch_gcnt", int'(glitch_cnt_o), 1);

    // Qualified fall on edge 7.
    hold(1'b0, 7);
    check("fall_edge6_pulse", int'(pulse_o), 1);
    cyc(1'b0);
    check("fall_edge7_pulse", int'(pulse_o), 0);
    hold(1'b0, 4);

    // Three-cycle high glitch from LOW.
    hold(1'b1, 3);
    hold(1'b0, 6);
    check("glitch_high_pulse", int'(pulse_o), 0);
    check("glitch_high_busy", int'(busy_o), 0);
    check("glitch_high_gcnt", int'(glitch_cnt_o), 2);

    // Bounce 1,0,1,0 then settle high: single rise 7 edges after final rise.
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
    hold(1'b1, 7);
    check("bounce_edge6_pulse", int'(pulse_o), 0);
    cyc(1'b1);
    check("bounce_edge7_pulse", int'(pulse_o), 1);
    check("bounce_gcnt", int'(glitch_cnt_o), 4);
    hold(1'b0, 10);

    // Saturation after 20 more glitches.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    hold(1'b0, 3);
    check("saturate_gcnt", int'(glitch_cnt_o), GMAX);

    // Clear coincident with a glitch wins.
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0, 1'b1); cyc(1'b0);
    check("clear_vs_glitch_gcnt", int'(glitch_cnt_o), 0);

    // Reset while HIGH, input still high: re-qualified from scratch.
    hold(1'b1, 10);
    check("pre_reset_pulse", int'(pulse_o), 1);
    cyc(1'b1, 1'b0, 1'b1);
    hold(1'b1, 6);
    check("post_reset_edge6_pulse", int'(pulse_o), 0);
    cyc(1'b1);
    check("post_reset_edge7_pulse", int'(pulse_o), 1);

    // Randomised bouncing with occasional clears and resets.
    for (int seg = 0; seg < 600; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        cyc(lvl, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 299) == 0));
      end
    end

    @(posedge clk_i);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
